bsg_front_side_bus_hop_in: RTL and testbench

Ring-ingress stage of a front-side-bus hop: accepts one word per cycle from the upstream ring link, buffers it in a two-entry FIFO, and steers each word to the local node, to the forward (pass-through) output, or to both (broadcast) according to a destination-ID field. The forward output feeds the pass-through input (`v_i[1]`/`data_i[63:32]`) of the same hop's ring-egress stage. The local output feeds the node client. Both outputs use valid/yumi handshakes.

---
 rtl/bsg_front_side_bus_hop_in_if.sv | 22 ++
 rtl/bsg_front_side_bus_hop_in.sv | 89 ++++++++
 tb/tb_bsg_front_side_bus_hop_in.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_front_side_bus_hop_in_if.sv
// Ring-ingress link bundle: upstream word/valid/ready plus the local/forward
// valid-yumi outputs that share one head word.
interface bsg_front_side_bus_hop_in_if #(
  parameter int unsigned width_p = 32
);
  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               ready_o;
  logic [1:0]         v_o;
  logic [width_p-1:0] data_o;
  logic [1:0]         yumi_i;

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o
  );

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o
  );
endinterface

// File: rtl/bsg_front_side_bus_hop_in.sv
// Front-side-bus hop ingress: two-entry FIFO that steers each word to the
// local node, the forward path, or both, tracking partially served broadcasts.
module bsg_front_side_bus_hop_in #(
  parameter int unsigned width_p    = 32,
  parameter int unsigned id_width_p = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [id_width_p-1:0] node_id_i,
  bsg_front_side_bus_hop_in_if.slave link
);

  localparam int unsigned depth_lp = 2;
  localparam logic [id_width_p-1:0] bcast_id_lp = '1;

  logic [width_p-1:0]    data_r [depth_lp];
  logic [1:0]            mask_r [depth_lp];
  logic                  head_r;
  logic                  tail_r;
  logic                  full_r;
  logic                  empty_r;
  logic [1:0]            served_r;

  logic [id_width_p-1:0] dest;
  logic [1:0]            route_mask;
  logic [1:0]            remaining;
  logic [1:0]            v_out;
  logic [1:0]            yumi_eff;
  logic                  enq;
  logic                  deq;
  logic                  partial;

  // Route mask at enqueue; broadcast wins even over an all-ones node ID
  always_comb begin
    dest       = link.data_i[width_p-1 -: id_width_p];
    route_mask = 2'b10;
    if (dest == bcast_id_lp)
      route_mask = 2'b11;
    else if (dest == node_id_i)
      route_mask = 2'b01;
  end

  // Head targets still owed; consume bits outside v_o are ignored
  always_comb begin
    remaining = mask_r[head_r] & ~served_r;
    v_out     = empty_r ? 2'b00 : remaining;
    yumi_eff  = link.yumi_i & v_out;
    deq       = (yumi_eff != 2'b00) && ((remaining & ~yumi_eff) == 2'b00);
    partial   = (yumi_eff != 2'b00) && !deq;
  end

  assign link.ready_o = reset_n_i & ~full_r;
  assign link.v_o     = v_out;
  assign link.data_o  = data_r[head_r];
  assign enq          = link.v_i & link.ready_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r   <= 1'b0;
      tail_r   <= 1'b0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      served_r <= 2'b00;
    end else begin
      if (enq) tail_r <= ~tail_r;
      if (deq) head_r <= ~head_r;
      if (enq && !deq) begin
        empty_r <= 1'b0;
        full_r  <= ~empty_r;
      end else if (deq && !enq) begin
        full_r  <= 1'b0;
        empty_r <= ~full_r;
      end
      if (deq)
        served_r <= 2'b00;
      else if (partial)
        served_r <= served_r | yumi_eff;
    end
  end

  // Payload storage carries no reset; occupancy flags qualify it
  always_ff @(posedge clk_i) begin
    if (enq) begin
      data_r[tail_r] <= link.data_i;
      mask_r[tail_r] <= route_mask;
    end
  end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_in.sv
// Self-checking bench for the hop ingress stage against a queue-of-pending-targets model.
module tb_bsg_front_side_bus_hop_in;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] node_id;

  bsg_front_side_bus_hop_in_if #(.width_p(32)) link();

  bsg_front_side_bus_hop_in #(.width_p(32), .id_width_p(4)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .node_id_i (node_id),
    .link      (link)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  pend;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge clk)
    if (reset_n)
      assert ((link.yumi_i & ~link.v_o) == 2'b00)
        else $error("protocol violation: yumi without valid");

  function automatic logic [1:0] route(input logic [31:0] d);
    logic [3:0] dest;
    dest = d[31:28];
    if (dest == 4'hF) return 2'b11;
    if (dest == node_id) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [1:0] exp_v();
    return (q.size() == 0) ? 2'b00 : q[0].pend;
  endfunction

  function automatic logic exp_ready();
    return reset_n && (q.size() < 2);
  endfunction

  function automatic logic [31:0] exp_data();
    return (q.size() == 0) ? 32'h0 : q[0].data;
  endfunction

  // Drive one cycle's inputs at the falling edge; consume only what is offered
  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] y);
    @(negedge clk);
    link.v_i    = v;
    link.data_i = d;
    link.yumi_i = y & link.v_o;
  endtask

  // Advance the model by the transfers happening at the next rising edge
  task automatic tick();
    logic       acc;
    logic [1:0] y;
    ent_t       h;
    acc = link.v_i && exp_ready();
    y   = link.yumi_i & exp_v();
    if (y != 2'b00) begin
      h = q[0];
      h.pend = h.pend & ~y;
      if (h.pend == 2'b00) void'(q.pop_front());
      else q[0] = h;
    end
    if (acc) q.push_back('{data: link.data_i, pend: route(link.data_i)});
    @(posedge clk);
  endtask

  task automatic test_reset();
    link.v_i = 1'b0; link.data_i = '0; link.yumi_i = 2'b00;
    node_id = 4'h3;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #12;
    n_checks++;
    if (link.v_o !== 2'b00 || link.ready_o !== 1'b0)
      $display("FAIL reset_hold: v_o=%b ready=%b want v_o=00 ready=0", link.v_o, link.ready_o);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (link.v_o !== 2'b00 || link.ready_o !== 1'b1)
      $display("FAIL reset_release: v_o=%b ready=%b want v_o=00 ready=1", link.v_o, link.ready_o);
    else n_pass++;
  endtask

  task automatic test_local_unicast();
    drive(1'b1, 32'h3000_00AA, 2'b11);
    n_checks++;
    if (link.v_o !== 2'b00 || link.ready_o !== 1'b1)
      $display("FAIL local_accept: v_o=%b ready=%b want v_o=00 ready=1", link.v_o, link.ready_o);
    else n_pass++;
    tick();
    drive(1'b0, 32'h0, 2'b11);
    n_checks++;
    if (link.v_o !== 2'b01 || link.data_o !== 32'h3000_00AA)
      $display("FAIL local_deliver: v_o=%b data=%h want v_o=01 data=300000aa", link.v_o, link.data_o);
    else n_pass++;
    tick();
    drive(1'b0, 32'h0, 2'b11);
    n_checks++;
    if (link.v_o !== 2'b00)
      $display("FAIL local_gone: v_o=%b want 00", link.v_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_forward_backpressure();
    logic [31:0] w[3] = '{32'h5000_0001, 32'h7000_0002, 32'h3000_0003};
    int idx = 0;
    bit third_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(idx < 3, w[(idx < 3) ? idx : 2], (c < 4) ? 2'b00 : 2'b11);
      n_checks++;
      if (link.v_o !== exp_v() || link.ready_o !== exp_ready() ||
          (exp_v() != 2'b00 && link.data_o !== exp_data()))
        $display("FAIL fwd_model c%0d: v_o=%b ready=%b data=%h want v_o=%b ready=%b data=%h",
                 c, link.v_o, link.ready_o, link.data_o, exp_v(), exp_ready(), exp_data());
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if (link.v_o !== 2'b10 || link.data_o !== 32'h5000_0001)
          $display("FAIL fwd_head: v_o=%b data=%h want v_o=10 data=50000001", link.v_o, link.data_o);
        else n_pass++;
      end
      if (c == 2 || c == 3) begin
        n_checks++;
        if (link.ready_o !== 1'b0)
          $display("FAIL fwd_full c%0d: ready=%b want 0", c, link.ready_o);
        else n_pass++;
      end
      if (link.v_o == 2'b01 && link.data_o == 32'h3000_0003) third_seen = 1'b1;
      if (link.v_i && exp_ready()) idx++;
      tick();
    end
    n_checks++;
    if (!third_seen || idx != 3 || q.size() != 0)
      $display("FAIL fwd_third: seen=%0b accepted=%0d left=%0d want seen=1 accepted=3 left=0",
               third_seen, idx, q.size());
    else n_pass++;
  endtask

  task automatic test_split_broadcast();
    logic [1:0] ys[4] = '{2'b01, 2'b00, 2'b00, 2'b10};
    logic [1:0] ev[4] = '{2'b11, 2'b10, 2'b10, 2'b10};
    drive(1'b1, 32'hF000_00BB, 2'b00);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, ys[i]);
      n_checks++;
      if (link.v_o !== ev[i] || link.data_o !== 32'hF000_00BB || link.v_o !== exp_v())
        $display("FAIL split_bcast s%0d: v_o=%b data=%h want v_o=%b data=f00000bb",
                 i, link.v_o, link.data_o, ev[i]);
      else n_pass++;
      tick();
    end
    drive(1'b0, 32'h0, 2'b00);
    n_checks++;
    if (link.v_o !== 2'b00)
      $display("FAIL split_done: v_o=%b want 00", link.v_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_same_cycle_bcast();
    drive(1'b1, 32'hF000_0001, 2'b00);
    tick();
    drive(1'b1, 32'h3000_0002, 2'b11);
    n_checks++;
    if (link.v_o !== 2'b11 || link.data_o !== 32'hF000_0001)
      $display("FAIL bcast_both_head: v_o=%b data=%h want v_o=11 data=f0000001", link.v_o, link.data_o);
    else n_pass++;
    tick();
    drive(1'b0, 32'h0, 2'b00);
    n_checks++;
    if (link.v_o !== 2'b01 || link.data_o !== 32'h3000_0002)
      $display("FAIL bcast_both_next: v_o=%b data=%h want v_o=01 data=30000002", link.v_o, link.data_o);
    else n_pass++;
    tick();
    drive(1'b0, 32'h0, 2'b11);
    tick();
    drive(1'b0, 32'h0, 2'b00);
    n_checks++;
    if (link.v_o !== 2'b00 || q.size() != 0)
      $display("FAIL bcast_both_drain: v_o=%b left=%0d want v_o=00 left=0", link.v_o, q.size());
    else n_pass++;
    tick();
  endtask

  task automatic test_stream();
    int sent = 0;
    logic [31:0] d;
    for (int c = 0; c < 110; c++) begin
      d = $urandom;
      if (d[31:28] == 4'hF) d[31:28] = 4'h3;
      drive(sent < 100, d, 2'b11);
      if (sent < 100) begin
        n_checks++;
        if (link.ready_o !== 1'b1)
          $display("FAIL stream_ready c%0d: ready=%b want 1", c, link.ready_o);
        else n_pass++;
      end
      n_checks++;
      if (link.v_o !== exp_v() || (exp_v() != 2'b00 && link.data_o !== exp_data()))
        $display("FAIL stream_model c%0d: v_o=%b data=%h want v_o=%b data=%h",
                 c, link.v_o, link.data_o, exp_v(), exp_data());
      else n_pass++;
      if (link.v_i && exp_ready()) sent++;
      tick();
    end
    n_checks++;
    if (sent != 100 || q.size() != 0)
      $display("FAIL stream_count: sent=%0d left=%0d want sent=100 left=0", sent, q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [3:0]  pick;
    for (int c = 0; c < 400; c++) begin
      d = $urandom;
      pick = 4'($urandom_range(0, 7));
      d[31:28] = (pick < 2) ? 4'hF : (pick < 4) ? node_id : 4'($urandom_range(0, 14));
      drive($urandom_range(0, 9) < 7, d, 2'($urandom));
      n_checks++;
      if (link.v_o !== exp_v() || link.ready_o !== exp_ready() ||
          (exp_v() != 2'b00 && link.data_o !== exp_data()))
        $display("FAIL random_model c%0d: v_o=%b ready=%b data=%h want v_o=%b ready=%b data=%h",
                 c, link.v_o, link.ready_o, link.data_o, exp_v(), exp_ready(), exp_data());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 2'b11);
      tick();
    end
    drive(1'b1, 32'hF000_00CC, 2'b00);
    tick();
    drive(1'b1, 32'h5000_00DD, 2'b01);
    tick();
    drive(1'b0, 32'h0, 2'b00);
    n_checks++;
    if (link.v_o !== 2'b10 || link.ready_o !== 1'b0 || link.data_o !== 32'hF000_00CC)
      $display("FAIL rst_setup: v_o=%b ready=%b data=%h want v_o=10 ready=0 data=f00000cc",
               link.v_o, link.ready_o, link.data_o);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    n_checks++;
    if (link.v_o !== 2'b00 || link.ready_o !== 1'b0)
      $display("FAIL rst_async: v_o=%b ready=%b want v_o=00 ready=0", link.v_o, link.ready_o);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (link.v_o !== 2'b00 || link.ready_o !== 1'b1)
      $display("FAIL rst_release: v_o=%b ready=%b want v_o=00 ready=1", link.v_o, link.ready_o);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 2'b11);
      n_checks++;
      if (link.v_o !== 2'b00 || link.ready_o !== 1'b1)
        $display("FAIL rst_stale c%0d: v_o=%b ready=%b want v_o=00 ready=1", i, link.v_o, link.ready_o);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_local_unicast();
    test_forward_backpressure();
    test_split_broadcast();
    test_same_cycle_bcast();
    test_stream();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
